// File: rtl/fp16_pkg.sv
// Shared FP16 field widths, constants and payload structs for the unpacker slice.
package fp16_pkg;

    localparam int unsigned FP16_EXP_BIAS  = 15;
    localparam int unsigned FP16_EXP_W     = 5;
    localparam int unsigned FP16_FRAC_W    = 10;
    localparam int unsigned FP16_LZ_W      = 4;
    localparam int unsigned FP16_UNP_EXP_W = 7;
    localparam int unsigned FP16_UNP_MAN_W = FP16_FRAC_W + 1;

    localparam logic [FP16_EXP_W-1:0] FP16_EXP_INFNAN = 5'h1F;

    typedef struct packed {
        logic zero;
        logic sub;
        logic inf;
        logic nan;
        logic snan;
    } fp16_flags_t;

    // Raw fields plus class, as captured by the first pipeline stage.
    typedef struct packed {
        logic                   sign;
        logic [FP16_EXP_W-1:0]  exp;
        logic [FP16_FRAC_W-1:0] frac;
        fp16_flags_t            flags;
    } fp16_split_t;

    typedef struct packed {
        logic                            sign;
        logic signed [FP16_UNP_EXP_W-1:0] exp;
        logic [FP16_UNP_MAN_W-1:0]       man;
        fp16_flags_t                     flags;
    } fp16_unp_t;

endpackage

// File: rtl/fp16_unpacker_if.sv
// Valid/ready operand-in and unpacked-result-out bundle for fp16_unpacker.
interface fp16_unpacker_if #(
    parameter int unsigned EXP_W = 7,
    parameter int unsigned MAN_W = 11
);
    import fp16_pkg::*;

    logic                                in_valid;
    logic                                in_ready;
    logic [FP16_EXP_W+FP16_FRAC_W:0]     In_FP16;
    logic                                out_valid;
    logic                                out_ready;
    logic                                Unp_Sign;
    logic signed [EXP_W-1:0]             Unp_Exp;
    logic [MAN_W-1:0]                    Unp_Man;
    logic                                Is_Zero;
    logic                                Is_Sub;
    logic                                Is_Inf;
    logic                                Is_NaN;
    logic                                Is_SNaN;

    modport slave (
        input  in_valid, In_FP16, out_ready,
        output in_ready, out_valid, Unp_Sign, Unp_Exp, Unp_Man,
               Is_Zero, Is_Sub, Is_Inf, Is_NaN, Is_SNaN
    );

    modport master (
        output in_valid, In_FP16, out_ready,
        input  in_ready, out_valid, Unp_Sign, Unp_Exp, Unp_Man,
               Is_Zero, Is_Sub, Is_Inf, Is_NaN, Is_SNaN
    );
endinterface

// File: rtl/fp16_lzc10.sv
// Combinational leading-zero count of a 10-bit fraction; returns 10 for all-zero input.
module fp16_lzc10
    import fp16_pkg::*;
(
    input  logic [FP16_FRAC_W-1:0] value,
    output logic [FP16_LZ_W-1:0]   count
);

    // Scanning upward lets the highest set bit win.
    always_comb begin
        count = 4'd10;
        for (int i = 0; i < int'(FP16_FRAC_W); i++) begin
            if (value[i]) count = 4'(9 - i);
        end
    end

endmodule

// File: rtl/fp16_unpacker.sv
// Two-stage elastic FP16 operand unpacker: split/classify, then normalise.
// FP16_SUBNORM_NORM_EN normalises subnormals; otherwise they flush to signed zero.
module fp16_unpacker
    import fp16_pkg::*;
#(
    parameter int unsigned EXP_W = 7,
    parameter int unsigned MAN_W = 11
) (
    input  logic            clk,
    input  logic            rst_n,
    fp16_unpacker_if.slave  bus
);

    fp16_split_t split_c, s1;
    fp16_unp_t   unp_c, s2;
    logic        s1_valid, s2_valid;
    logic        s1_load, s2_load;

`ifdef FP16_SUBNORM_NORM_EN
    logic [FP16_LZ_W-1:0] lz_c, s1_lz;

    fp16_lzc10 u_lzc (
        .value (bus.In_FP16[FP16_FRAC_W-1:0]),
        .count (lz_c)
    );
`endif

    assign s2_load     = ~s2_valid | bus.out_ready;
    assign s1_load     = ~s1_valid | s2_load;
    assign bus.in_ready = s1_load;

    // Stage 1 field split and classification.
    always_comb begin
        logic e_zero, e_ones, f_nz;
        split_c.sign = bus.In_FP16[FP16_EXP_W+FP16_FRAC_W];
        split_c.exp  = bus.In_FP16[FP16_EXP_W+FP16_FRAC_W-1:FP16_FRAC_W];
        split_c.frac = bus.In_FP16[FP16_FRAC_W-1:0];
        e_zero = (split_c.exp == '0);
        e_ones = (split_c.exp == FP16_EXP_INFNAN);
        f_nz   = |split_c.frac;
`ifdef FP16_SUBNORM_NORM_EN
        split_c.flags.zero = e_zero & ~f_nz;
`else
        split_c.flags.zero = e_zero;
`endif
        split_c.flags.sub  = e_zero & f_nz;
        split_c.flags.inf  = e_ones & ~f_nz;
        split_c.flags.nan  = e_ones & f_nz;
        split_c.flags.snan = e_ones & f_nz & ~split_c.frac[FP16_FRAC_W-1];
    end

    // Stage 2 exponent unbias and normalising shift.
    always_comb begin
        unp_c.sign  = s1.sign;
        unp_c.flags = s1.flags;
        unp_c.exp   = '0;
        unp_c.man   = '0;
        if (s1.flags.inf | s1.flags.nan) begin
            unp_c.exp = 7'sd16;
            unp_c.man = {1'b0, s1.frac};
        end else if (s1.flags.zero) begin
            unp_c.exp = '0;
            unp_c.man = '0;
`ifdef FP16_SUBNORM_NORM_EN
        end else if (s1.flags.sub) begin
            unp_c.exp = -7'sd15 - $signed({3'b000, s1_lz});
            unp_c.man = {1'b0, s1.frac} << (s1_lz + 4'd1);
`endif
        end else begin
            unp_c.exp = $signed({2'b00, s1.exp}) - $signed(7'(FP16_EXP_BIAS));
            unp_c.man = {1'b1, s1.frac};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1       <= '0;
            s2_valid <= 1'b0;
            s2       <= '0;
`ifdef FP16_SUBNORM_NORM_EN
            s1_lz    <= '0;
`endif
        end else begin
            if (s1_load) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1    <= split_c;
`ifdef FP16_SUBNORM_NORM_EN
                    s1_lz <= lz_c;
`endif
                end
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) s2 <= unp_c;
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.Unp_Sign  = s2.sign;
    assign bus.Unp_Exp   = EXP_W'(s2.exp);
    assign bus.Unp_Man   = MAN_W'(s2.man);
    assign bus.Is_Zero   = s2.flags.zero;
    assign bus.Is_Sub    = s2.flags.sub;
    assign bus.Is_Inf    = s2.flags.inf;
    assign bus.Is_NaN    = s2.flags.nan;
    assign bus.Is_SNaN   = s2.flags.snan;

endmodule

// File: tb/tb_fp16_unpacker.sv
// Bench for fp16_unpacker: directed literals, stall/ordering, random throttling, mid-stream reset.
module tb_fp16_unpacker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp16_unpacker_if #(.EXP_W(7), .MAN_W(11)) bif ();

    fp16_unpacker #(.EXP_W(7), .MAN_W(11)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    typedef struct packed {
        logic        sign;
        int          exp;
        logic [10:0] man;
        logic [4:0]  flags;   // {zero, sub, inf, nan, snan}
    } res_t;

    int tests = 0;
    int fails = 0;
    res_t q[$];

    task automatic chk(input string nm, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, req, req);
        end
    endtask

    // Value-level model: classify, then normalise subnormals by doubling until the hidden bit appears.
    function automatic res_t model(input logic [15:0] w);
        res_t r;
        int e = int'(w[14:10]);
        int f = int'(w[9:0]);
        int m;
        int x;
        r.sign = w[15]; r.exp = 0; r.man = '0; r.flags = '0;
        if (e == 31) begin
            r.exp = 16;
            r.man = 11'(f);
            if (f == 0)        r.flags = 5'b00100;
            else if (f >= 512) r.flags = 5'b00010;
            else               r.flags = 5'b00011;
        end else if (e == 0 && f == 0) begin
            r.flags = 5'b10000;
        end else if (e == 0) begin
`ifdef FP16_SUBNORM_NORM_EN
            m = f; x = -14;
            while (m < 1024) begin m = m * 2; x = x - 1; end
            r.exp = x; r.man = 11'(m); r.flags = 5'b01000;
`else
            r.flags = 5'b11000;
`endif
        end else begin
            m = 1024 + f; x = e - 15;
            r.exp = x; r.man = 11'(m);
        end
        return r;
    endfunction

    function automatic res_t actual();
        res_t a;
        a.sign  = bif.Unp_Sign;
        a.exp   = int'(bif.Unp_Exp);
        a.man   = bif.Unp_Man;
        a.flags = {bif.Is_Zero, bif.Is_Sub, bif.Is_Inf, bif.Is_NaN, bif.Is_SNaN};
        return a;
    endfunction

    // Scoreboard: every output transfer must match the oldest accepted input; stalled outputs must hold.
    logic hold = 1'b0;
    res_t held;
    always @(negedge clk) begin
        res_t cur, e;
        if (!rst_n) begin
            q.delete();
            hold = 1'b0;
        end else begin
            cur = actual();
            if (hold) chk("stall_stable", int'(bif.out_valid && (cur == held)), 1);
            if (bif.out_valid && bif.out_ready) begin
                if (q.size() == 0) chk("spurious_out", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("sb_sign",  int'(cur.sign),  int'(e.sign));
                    chk("sb_exp",   cur.exp,         e.exp);
                    chk("sb_man",   int'(cur.man),   int'(e.man));
                    chk("sb_flags", int'(cur.flags), int'(e.flags));
                end
            end
            hold = bif.out_valid && !bif.out_ready;
            held = cur;
            if (bif.in_valid && bif.in_ready) q.push_back(model(bif.In_FP16));
        end
    end

    task automatic check_out_zero(input string nm);
        chk({nm, "_valid"}, int'(bif.out_valid), 0);
        chk({nm, "_sign"},  int'(bif.Unp_Sign), 0);
        chk({nm, "_exp"},   int'(bif.Unp_Exp), 0);
        chk({nm, "_man"},   int'(bif.Unp_Man), 0);
        chk({nm, "_flags"}, int'(actual().flags), 0);
    endtask

    // Single word with out_ready=1: latency and literal output values; also pins the model.
    task automatic directed(input logic [15:0] w, input int s, input int x, input int m, input int fl);
        bit   ok = 0;
        int   lat = 0;
        res_t a, mm;
        string nm = $sformatf("dir_%04h", w);
        bif.In_FP16 = w; bif.in_valid = 1'b1;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (bif.in_ready) ok = 1;
        end
        chk({nm, "_accept"}, int'(ok), 1);
        @(posedge clk); #1 bif.in_valid = 1'b0;
        ok = 0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            lat++;
            if (bif.out_valid) ok = 1;
        end
        chk({nm, "_latency"}, ok ? lat : -1, 2);
        a = actual();
        chk({nm, "_sign"},  int'(a.sign), s);
        chk({nm, "_exp"},   a.exp, x);
        chk({nm, "_man"},   int'(a.man), m);
        chk({nm, "_flags"}, int'(a.flags), fl);
        mm = model(w);
        chk({nm, "_model_exp"}, mm.exp, x);
        chk({nm, "_model_man"}, int'(mm.man), m);
        chk({nm, "_model_flags"}, int'(mm.flags), fl);
        @(posedge clk); #1;
    endtask

    function automatic logic [15:0] rand_word();
        int sel = $urandom_range(0, 7);
        logic [15:0] w = 16'($urandom);
        if (sel == 0) w[14:10] = 5'h00;
        else if (sel == 1) w[14:10] = 5'h1F;
        else if (sel == 2) w[9:0] = '0;
        return w;
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    logic [15:0] st [4] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400};
    int          expseq [4] = '{0, 1, 1, 2};

    initial begin
        int acc, idx, n_out, sent, cyc;
        bit acc_now;

        bif.in_valid = 1'b0; bif.In_FP16 = '0; bif.out_ready = 1'b0;
        #1 check_out_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", int'(bif.in_ready), 1);
        check_out_zero("after_release");
        @(posedge clk); #1;

        bif.out_ready = 1'b1;
        directed(16'h3C00, 0, 0,   'h400, 'b00000);
        directed(16'hC000, 1, 1,   'h400, 'b00000);
        directed(16'h7BFF, 0, 15,  'h7FF, 'b00000);
        directed(16'h0400, 0, -14, 'h400, 'b00000);
`ifdef FP16_SUBNORM_NORM_EN
        directed(16'h0001, 0, -24, 'h400, 'b01000);
        directed(16'h03FF, 0, -15, 'h7FE, 'b01000);
`else
        directed(16'h0001, 0, 0,   'h000, 'b11000);
        directed(16'h83FF, 1, 0,   'h000, 'b11000);
`endif
        directed(16'h7C00, 0, 16,  'h000, 'b00100);
        directed(16'h7E00, 0, 16,  'h200, 'b00010);
        directed(16'h7D01, 0, 16,  'h101, 'b00011);
        directed(16'hFFFF, 1, 16,  'h3FF, 'b00010);
        directed(16'h8000, 1, 0,   'h000, 'b10000);

        // Back-to-back stream into a stalled consumer.
        bif.out_ready = 1'b0;
        acc = 0; idx = 0;
        bif.In_FP16 = st[0]; bif.in_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            acc_now = bif.in_ready;
            @(posedge clk); #1;
            if (acc_now) begin acc++; idx++; bif.In_FP16 = st[idx]; end
        end
        chk("b2b_accepts", acc, 2);
        chk("b2b_in_ready_low", int'(bif.in_ready), 0);
        bif.out_ready = 1'b1;
        n_out = 0;
        for (int c = 0; c < 40 && n_out < 4; c++) begin
            @(negedge clk);
            acc_now = bif.in_valid && bif.in_ready;
            if (bif.out_valid) begin
                chk($sformatf("b2b_exp%0d", n_out), int'(bif.Unp_Exp), expseq[n_out]);
                n_out++;
            end
            @(posedge clk); #1;
            if (acc_now) begin
                idx++;
                if (idx < 4) bif.In_FP16 = st[idx];
                else bif.in_valid = 1'b0;
            end
        end
        chk("b2b_count", n_out, 4);
        bif.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Random words under random valid/ready throttling.
        sent = 0; cyc = 0;
        while (sent < 10000 && cyc < 60000) begin
            cyc++;
            if (!bif.in_valid && $urandom_range(0, 3) != 0) begin
                bif.In_FP16 = rand_word();
                bif.in_valid = 1'b1;
            end
            bif.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc_now = bif.in_valid && bif.in_ready;
            @(posedge clk); #1;
            if (acc_now) begin sent++; bif.in_valid = 1'b0; end
        end
        chk("rand_sent", sent, 10000);
        bif.in_valid = 1'b0; bif.out_ready = 1'b1;
        for (int c = 0; c < 20 && q.size() != 0; c++) @(negedge clk);
        chk("rand_drained", q.size(), 0);
        @(posedge clk); #1;

        // Fill both stages, then reset mid-stream.
        bif.out_ready = 1'b0;
        bif.In_FP16 = 16'hC400; bif.in_valid = 1'b1;
        for (int c = 0; c < 10 && bif.in_ready; c++) begin
            @(posedge clk); #1;
        end
        chk("rst_full", int'(bif.in_ready), 0);
        chk("rst_pre_valid", int'(bif.out_valid), 1);
        bif.in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_out_zero("midrst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bif.out_ready = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", int'(bif.in_ready), 1);
        n_out = 0;
        repeat (10) begin
            @(negedge clk);
            if (bif.out_valid) n_out++;
        end
        chk("midrst_no_stale", n_out, 0);
        chk("final_sb_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
